// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in / parallel-out deserializer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sipo_pkg;

    // Deserializer control states. PARITY is only entered when SIPO_PARITY_EN
    // is defined, but the encoding is kept fixed so both builds share one type.
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        HOLD    = 2'd2
    } sipo_state_t;

    localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-to-parallel shift register with synchronous clear.
// Latency: a shifted bit is visible on q one cycle after shift_en; nxt shows the post-shift value combinationally.
// Backpressure: none; shifts whenever shift_en is high, clr has priority.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   shift_en    shift sin into the register this cycle
//   clr         discard contents (synchronous, wins over shift_en)
//   sin         serial input bit
//   q           current register contents
//   nxt         value q takes if shift_en is high this cycle
module sipo_shift_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] sr;

    // LSB-first: bits enter at the top and walk down, so the first bit ends in [0].
    // MSB-first: bits enter at the bottom and walk up, so the first bit ends in [WIDTH-1].
    generate
        if (MSB_FIRST) begin : g_msb
            assign nxt = {sr[WIDTH-2:0], sin};
        end else begin : g_lsb
            assign nxt = {sin, sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= nxt;
        end
    end

    assign q = sr;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer, double-buffered (shift register + output register).
// Latency: p_valid rises on the edge that accepts the last bit of a frame.
// Backpressure: if the output register is still full when a frame completes, s_ready drops until p_ready drains it.
//
// Optional feature macro: SIPO_PARITY_EN -- each word is followed by one even-parity
// bit and p_err = ^{word, parity_bit} travels with p_data. Undefined: p_err is tied 0.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   clr               synchronous abort of the partially collected (or held) word
//   s_valid/s_ready   serial bit handshake, s_data is the bit
//   p_valid/p_ready   parallel word handshake, p_data is the word
//   p_err             parity error flag for the word on p_data
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    input  logic             s_data,
    output logic             s_ready,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             p_err
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sipo_state_t      state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_nxt;
    logic             accept;
    logic             last_bit;
    logic             slot_free;
    logic             shift_en;

    assign accept    = s_valid && s_ready;
    assign last_bit  = (cnt == LAST_BIT);
    // The output register can take a new word if it is empty or being drained this edge.
    assign slot_free = !p_valid || p_ready;
    // Only data bits shift; a parity bit is consumed without disturbing the word.
    assign shift_en  = accept && (state == COLLECT);

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .clr      (clr),
        .sin      (s_data),
        .q        (sr_q),
        .nxt      (sr_nxt)
    );

`ifdef SIPO_PARITY_EN
    logic perr_q;
    logic perr_hold;   // parity result of a word parked in the shift register
    logic perr_calc;

    assign perr_calc = ^{sr_q, s_data};
    assign p_err     = perr_q;
`else
    assign p_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            s_ready <= 1'b1;
            cnt     <= '0;
            p_data  <= '0;
            p_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q    <= 1'b0;
            perr_hold <= 1'b0;
`endif
        end else begin
            // Drain by default; any load below overrides this on the same edge.
            if (p_valid && p_ready) begin
                p_valid <= 1'b0;
            end

            if (clr) begin
                // Drops the partial word, or the held word in HOLD; output side untouched.
                cnt     <= '0;
                state   <= COLLECT;
                s_ready <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        if (accept) begin
                            if (last_bit) begin
                                cnt <= '0;
`ifdef SIPO_PARITY_EN
                                state <= PARITY;
`else
                                if (slot_free) begin
                                    p_data  <= sr_nxt;
                                    p_valid <= 1'b1;
                                end else begin
                                    state   <= HOLD;
                                    s_ready <= 1'b0;
                                end
`endif
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end

                    PARITY: begin
`ifdef SIPO_PARITY_EN
                        if (accept) begin
                            if (slot_free) begin
                                p_data  <= sr_q;
                                p_valid <= 1'b1;
                                perr_q  <= perr_calc;
                                state   <= COLLECT;
                            end else begin
                                perr_hold <= perr_calc;
                                state     <= HOLD;
                                s_ready   <= 1'b0;
                            end
                        end
`else
                        state   <= COLLECT;
                        s_ready <= 1'b1;
`endif
                    end

                    HOLD: begin
                        // The completed word waits in the shift register until the
                        // output register drains; p_valid stays high across the swap.
                        if (p_valid && p_ready) begin
                            p_data  <= sr_q;
                            p_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                            perr_q  <= perr_hold;
`endif
                            state   <= COLLECT;
                            s_ready <= 1'b1;
                        end
                    end

                    default: begin
                        state   <= COLLECT;
                        s_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: one LSB-first and one MSB-first instance driven in parallel.
// Latency: n/a.
// Backpressure: n/a.
module tb_sipo_deser;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         clr;
    logic         s_valid;
    logic         s_data;
    logic         p_ready;
    logic         s_ready0, s_ready1;
    logic [W-1:0] p_data0, p_data1;
    logic         p_valid0, p_valid1;
    logic         p_err0, p_err1;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int drops  = 0;
    int words  = 0;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready0),
        .p_data  (p_data0),
        .p_valid (p_valid0),
        .p_ready (p_ready),
        .p_err   (p_err0)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready1),
        .p_data  (p_data1),
        .p_valid (p_valid1),
        .p_ready (p_ready),
        .p_err   (p_err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Words delivered by the LSB-first instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (p_valid0 && p_ready) words <= words + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[i] is the i-th bit sent; leaves s_valid high so frames can abut.
    task automatic send_frame(input logic [3:0] seq, input logic bad_par);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = seq[i];
            if (!s_ready0) drops++;
            tick();
        end
`ifdef SIPO_PARITY_EN
        s_valid = 1'b1;
        s_data  = (^seq) ^ bad_par;
        if (!s_ready0) drops++;
        tick();
`else
        if (bad_par) s_data = 1'b0;
`endif
    endtask

    initial begin
        int d0;
        int w0;
        rst_n   = 1'b1;
        clr     = 1'b0;
        s_valid = 1'b0;
        s_data  = 1'b0;
        p_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p_valid", 32'(p_valid0), 32'd0);
        check("rst_p_data",  32'(p_data0),  32'd0);
        check("rst_p_err",   32'(p_err0),   32'd0);
        check("rst_s_ready", 32'(s_ready0), 32'd1);
        rst_n = 1'b1;
        tick();
        check("post_rst_s_ready", 32'(s_ready0), 32'd1);

        // Bit order: 1,0,1,1
        p_ready = 1'b1;
        send_frame(4'b1101, 1'b0);
        check("order_p_valid",  32'(p_valid0), 32'd1);
        check("order_lsb_data", 32'(p_data0),  32'hD);
        check("order_msb_data", 32'(p_data1),  32'hB);
        check("order_p_err",    32'(p_err0),   32'd0);
        s_valid = 1'b0;
        tick();
        check("order_one_cycle", 32'(p_valid0), 32'd0);

        // Streaming: 1,1,1,1 then 0,1,0,0 with no gap
        d0 = drops;
        send_frame(4'b1111, 1'b0);
        check("stream1_valid", 32'(p_valid0), 32'd1);
        check("stream1_data",  32'(p_data0),  32'hF);
        send_frame(4'b0010, 1'b0);
        check("stream2_valid",    32'(p_valid0), 32'd1);
        check("stream2_lsb_data", 32'(p_data0),  32'h2);
        check("stream2_msb_data", 32'(p_data1),  32'h4);
        check("stream_no_drops",  32'(drops - d0), 32'd0);
        s_valid = 1'b0;
        tick();

        // Backpressure
        p_ready = 1'b0;
        send_frame(4'b1101, 1'b0);
        check("bp1_valid",   32'(p_valid0), 32'd1);
        check("bp1_data",    32'(p_data0),  32'hD);
        check("bp1_s_ready", 32'(s_ready0), 32'd1);
        send_frame(4'b0010, 1'b0);
        check("bp2_s_ready", 32'(s_ready0), 32'd0);
        check("bp2_data",    32'(p_data0),  32'hD);
        s_valid = 1'b0;
        tick();
        check("bp_hold_data",    32'(p_data0),  32'hD);
        check("bp_hold_s_ready", 32'(s_ready0), 32'd0);
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        check("bp_release_data",  32'(p_data0),  32'h2);
        check("bp_release_valid", 32'(p_valid0), 32'd1);
        check("bp_release_ready", 32'(s_ready0), 32'd1);
        p_ready = 1'b1;
        tick();
        check("bp_drained", 32'(p_valid0), 32'd0);

        // clr abort of a partial word
        w0 = words;
        s_valid = 1'b1;
        s_data  = 1'b1;
        tick();
        s_data  = 1'b0;
        tick();
        s_valid = 1'b0;
        clr     = 1'b1;
        tick();
        clr = 1'b0;
        send_frame(4'b1111, 1'b0);
        check("clr_valid", 32'(p_valid0), 32'd1);
        check("clr_data",  32'(p_data0),  32'hF);
        s_valid = 1'b0;
        tick();
        check("clr_one_word", 32'(words - w0), 32'd1);

        // clr on the last data bit: no word
        w0 = words;
        s_valid = 1'b1;
        s_data  = 1'b1;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr     = 1'b0;
        s_valid = 1'b0;
        repeat (2) tick();
        check("clr_last_no_word",  32'(words - w0), 32'd0);
        check("clr_last_no_valid", 32'(p_valid0),   32'd0);
        send_frame(4'b0101, 1'b0);
        check("clr_last_realign", 32'(p_data0), 32'h5);
        s_valid = 1'b0;
        tick();

        // Asynchronous reset mid-word
        p_ready = 1'b0;
        send_frame(4'b1010, 1'b0);
        check("mid_rst_pre_data", 32'(p_data0), 32'hA);
        s_data = 1'b1;
        repeat (2) tick();
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_p_valid", 32'(p_valid0), 32'd0);
        check("mid_rst_p_data",  32'(p_data0),  32'd0);
        check("mid_rst_s_ready", 32'(s_ready0), 32'd1);
        #1 rst_n = 1'b1;
        tick();
        p_ready = 1'b1;
        send_frame(4'b1100, 1'b0);
        check("mid_rst_word_lsb", 32'(p_data0),  32'hC);
        check("mid_rst_word_msb", 32'(p_data1),  32'h3);
        check("mid_rst_valid",    32'(p_valid0), 32'd1);
        s_valid = 1'b0;
        tick();

`ifdef SIPO_PARITY_EN
        send_frame(4'b1101, 1'b0);
        check("par_good_data", 32'(p_data0), 32'hD);
        check("par_good_err",  32'(p_err0),  32'd0);
        s_valid = 1'b0;
        tick();
        send_frame(4'b1101, 1'b1);
        check("par_bad_data", 32'(p_data0), 32'hD);
        check("par_bad_err",  32'(p_err0),  32'd1);
        s_valid = 1'b0;
        tick();
`else
        check("no_par_err", 32'(p_err0), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
